add_round_key_pipe: RTL

- Registered, handshaked, parametrised AddRoundKey stage for the AES-192 encryption datapath.
- XORs a BLOCK_W-bit state with a stored round key, LANE_W bits per clock, over BEATS = BLOCK_W/LANE_W cycles.
- The key is held in an internal register loaded on demand.
- Valid/ready on both sides lets it sit between the input buffer and the round pipeline.
- A bypass mode passes the block through unmodified with identical latency.

---
 rtl/add_round_key_pipe_if.sv | 32 +++
 rtl/add_round_key_pipe.sv | 124 ++++++++++++
 2 files changed

// File: rtl/add_round_key_pipe_if.sv
// add_round_key_pipe_if
//   Bundles the key-load, input-side and output-side handshakes of the
//   AddRoundKey stage. Vectors use ascending bit order: index 0 is the MSB.
//   master : upstream/downstream driver (testbench, surrounding datapath)
//   slave  : the add_round_key_pipe stage itself
//   Signals: key_load/cipher_key (key register load), in_valid/in_ready/
//   in_data/bypass (block input), out_valid/out_ready/out_data (result),
//   busy (stage is in RUN or DONE).
interface add_round_key_pipe_if #(
  parameter int BLOCK_W = 128
);
  logic               key_load;
  logic [0:BLOCK_W-1] cipher_key;
  logic               in_valid;
  logic               in_ready;
  logic [0:BLOCK_W-1] in_data;
  logic               bypass;
  logic               out_valid;
  logic               out_ready;
  logic [0:BLOCK_W-1] out_data;
  logic               busy;

  modport master (
    output key_load, cipher_key, in_valid, in_data, bypass, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  key_load, cipher_key, in_valid, in_data, bypass, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/add_round_key_pipe.sv
// add_round_key_pipe
//   Handshaked AddRoundKey stage. A BLOCK_W-bit state is XORed with the
//   stored round key LANE_W bits per clock (lane 0 = most significant lane
//   first), taking BEATS = BLOCK_W/LANE_W cycles. A bypass flag captured
//   with the block suppresses the XOR while keeping the same latency.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, clears every register
//     bus   : add_round_key_pipe_if.slave (key load, in/out handshakes, busy)
//   BLOCK_W must be a multiple of 8 and LANE_W must divide BLOCK_W.
module add_round_key_pipe #(
  parameter int BLOCK_W = 128,
  parameter int LANE_W  = 32
) (
  input logic clk,
  input logic rst_n,
  add_round_key_pipe_if.slave bus
);
  localparam int BEATS = BLOCK_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_reg, state_next;
  logic [0:BLOCK_W-1] key_reg, key_next;
  logic [0:BLOCK_W-1] data_reg, data_next;
  logic [0:BLOCK_W-1] out_reg, out_next;
  logic [0:BLOCK_W-1] data_mix;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               bypass_reg, bypass_next;
  logic               in_ready, out_valid, busy;

  // Data register with only the lane selected by the beat counter XORed.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      localparam logic [CNT_W-1:0] LANE_IDX = CNT_W'(gi);
      assign data_mix[gi*LANE_W +: LANE_W] =
        (cnt_reg == LANE_IDX && !bypass_reg)
          ? (data_reg[gi*LANE_W +: LANE_W] ^ key_reg[gi*LANE_W +: LANE_W])
          : data_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      key_reg    <= '0;
      data_reg   <= '0;
      out_reg    <= '0;
      cnt_reg    <= '0;
      bypass_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      key_reg    <= key_next;
      data_reg   <= data_next;
      out_reg    <= out_next;
      cnt_reg    <= cnt_next;
      bypass_reg <= bypass_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    key_next    = key_reg;
    data_next   = data_reg;
    out_next    = out_reg;
    cnt_next    = cnt_reg;
    bypass_next = bypass_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        // The key lands on the same edge as an accept, so that block
        // already sees the new key during RUN.
        if (bus.key_load) key_next = bus.cipher_key;
        if (bus.in_valid) begin
          data_next   = bus.in_data;
          bypass_next = bus.bypass;
          cnt_next    = '0;
          state_next  = ST_RUN;
        end
      end

      ST_RUN: begin
        busy      = 1'b1;
        data_next = data_mix;
        cnt_next  = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_BEAT) begin
          out_next   = data_mix;
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // A new block can only enter when the current result is taken.
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            data_next   = bus.in_data;
            bypass_next = bus.bypass;
            cnt_next    = '0;
            state_next  = ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_data  = out_reg;
endmodule
